refill_arbiter: RTL and testbench
=================================

Name: refill_arbiter

Overview:
Shares the single main-memory read port between the instruction-cache and data-cache line-fill controllers. Each controller raises a line-refill request with a miss address. The arbiter grants one requester for a whole line burst, drives the main-memory read, and counts returned beats. It steers each beat's valid and data to the granted side and pulses done on the last beat. It sits between the two L1 cache controllers and the main-memory model.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, main-memory beat width
WORDS_PER_LINE, 4, beats per cache line; power of 2, >=2
OFFSET_W, $clog2(WORDS_PER_LINE*DATA_W/8), byte-offset bits cleared for line alignment (localparam)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_i  in  1  imem refill request; held until done_i
addr_i  in  ADDR_W  imem miss address
req_d  in  1  dmem refill request; held until done_d
addr_d  in  ADDR_W  dmem miss address
gnt_i  out  1  imem owns memory port
gnt_d  out  1  dmem owns memory port
valid_i  out  1  beat valid to imem (drives its line-buffer we/next)
valid_d  out  1  beat valid to dmem
rdata  out  DATA_W  beat data, shared, qualified by valid_i/valid_d
beat_idx  out  $clog2(WORDS_PER_LINE)  index of current beat within line
done_i  out  1  one-cycle pulse on last imem beat
done_d  out  1  one-cycle pulse on last dmem beat
mm_re  out  1  main-memory read enable, held for entire burst
mm_addr  out  ADDR_W  line-aligned burst base address, registered
mm_valid  in  1  main memory beat valid
mm_data  in  DATA_W  main memory beat data

Behaviour:
- Reset: state=IDLE, beat count=0, last_winner=DMEM (imem wins first tie). All outputs are 0, including mm_addr.
- States:
  - IDLE: if any req, pick winner, register mm_addr = winner addr with low OFFSET_W bits zeroed, go to BURST. Otherwise stay.
  - BURST: gnt_<winner>=1, mm_re=1. Each cycle with mm_valid=1: valid_<winner>=1, rdata=mm_data, beat_idx=count, then count++. On the beat where count==WORDS_PER_LINE-1: done_<winner>=1 in the same cycle, count clears, go to RELEASE.
  - RELEASE: all outputs 0 for exactly one cycle (mm_re drops so memory sees the burst end), update last_winner, go to IDLE.
- Arbitration in IDLE:
  - Single req wins.
  - Both asserted: round-robin, the side that is not last_winner wins.
- Latency: req seen in IDLE at cycle N gives gnt/mm_re high at N+1. Minimum gap between bursts is 2 cycles (RELEASE, IDLE).
- Combinational in BURST: valid_x and rdata are combinational from mm_valid/mm_data; no added latency. rdata=0 when no valid.
- mm_valid outside BURST is ignored; no valid/done and no count change.
- Loser's req stays pending, with no grant, until a later IDLE. No starvation: with both requesting continuously, grants alternate.
- Winner dropping req mid-burst is not allowed by protocol. The arbiter ignores it and completes the burst, still forwarding beats.
- Address change while granted is ignored; mm_addr is stable for the burst.
- Reset mid-burst: next cycle IDLE, all outputs 0, count 0, last_winner=DMEM. The partial line is abandoned and no done is issued.
- Beat counter wraps only via the last-beat clear; it never exceeds WORDS_PER_LINE-1.
- gnt_i and gnt_d are never both 1. At most one valid_x and one done_x are high per cycle.

Optional Feature:
ARB_IMEM_PRIORITY_EN:
- Defined: fixed priority. Imem always wins simultaneous requests and last_winner is unused. Dmem may starve under a continuous imem stream.
- Undefined: round-robin as above.

Test Plan:
1. Single imem miss: req_i=1, addr_i=0x0000_1234, 4 consecutive mm_valid beats (0xA0..0xA3) -> mm_addr=0x0000_1230 from next cycle; valid_i on 4 cycles with beat_idx 0..3; done_i with 0xA3; gnt_i low after RELEASE.
2. Simultaneous requests from reset: req_i=req_d=1 held -> imem served first, dmem second, then imem, alternating; one RELEASE+IDLE gap each time. With ARB_IMEM_PRIORITY_EN, imem only.
3. Gapped beats: mm_valid pattern 1,0,0,1,1,0,1 -> exactly 4 valid_d pulses, beat_idx advances only on valid, done_d on the 7th cycle of the pattern.
4. Stray mm_valid in IDLE/RELEASE with rdata 0xDEAD -> no valid/done, count stays 0, next burst starts at beat_idx 0.
5. Reset after 2 beats of a dmem burst -> next cycle all outputs 0, no done_d. Re-requested line restarts at beat 0; imem wins a tie.
6. Late request: req_d raised during imem burst -> gnt_d asserted exactly 2 cycles after done_i.

Source files
------------

// File: rtl/refill_arbiter_if.sv
// Refill arbiter bus: two L1 line-fill requesters plus the main-memory read port.
// master = arbiter side, slave = cache controllers / memory side.
interface refill_arbiter_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic              req_i;
    logic [ADDR_W-1:0] addr_i;
    logic              req_d;
    logic [ADDR_W-1:0] addr_d;
    logic              gnt_i;
    logic              gnt_d;
    logic              valid_i;
    logic              valid_d;
    logic [DATA_W-1:0] rdata;
    logic [IDX_W-1:0]  beat_idx;
    logic              done_i;
    logic              done_d;
    logic              mm_re;
    logic [ADDR_W-1:0] mm_addr;
    logic              mm_valid;
    logic [DATA_W-1:0] mm_data;

    modport master (
        input  req_i, addr_i, req_d, addr_d,
        input  mm_valid, mm_data,
        output gnt_i, gnt_d, valid_i, valid_d,
        output rdata, beat_idx, done_i, done_d,
        output mm_re, mm_addr
    );

    modport slave (
        output req_i, addr_i, req_d, addr_d,
        output mm_valid, mm_data,
        input  gnt_i, gnt_d, valid_i, valid_d,
        input  rdata, beat_idx, done_i, done_d,
        input  mm_re, mm_addr
    );
endinterface

// File: rtl/refill_arbiter.sv
// Shares the main-memory read port between imem and dmem line refills.
// Define ARB_IMEM_PRIORITY_EN for fixed imem priority instead of round-robin.
module refill_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic clk,
    input  logic reset,
    refill_arbiter_if.master bus
);
    localparam int IDX_W    = $clog2(WORDS_PER_LINE);
    localparam int OFFSET_W = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        RELEASE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  count;
    logic              owner_d;
    logic              gnt_i_q;
    logic              gnt_d_q;
    logic [ADDR_W-1:0] addr_q;
    logic              win_d;
    logic              beat;
    logic              last;
`ifndef ARB_IMEM_PRIORITY_EN
    logic              last_dmem;
`endif

    always_comb begin
`ifdef ARB_IMEM_PRIORITY_EN
        win_d = bus.req_d && !bus.req_i;
`else
        // On a tie the side that did not win last time goes next
        win_d = bus.req_d && (!bus.req_i || !last_dmem);
`endif
    end

    assign beat = (state == BURST) && bus.mm_valid;
    assign last = beat && (count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            owner_d <= 1'b0;
            gnt_i_q <= 1'b0;
            gnt_d_q <= 1'b0;
            addr_q  <= '0;
`ifndef ARB_IMEM_PRIORITY_EN
            last_dmem <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_i || bus.req_d) begin
                        state   <= BURST;
                        owner_d <= win_d;
                        gnt_i_q <= !win_d;
                        gnt_d_q <= win_d;
                        addr_q  <= (win_d ? bus.addr_d : bus.addr_i)
                                   & LINE_MASK;
                    end
                end
                BURST: begin
                    if (last) begin
                        state   <= RELEASE;
                        count   <= '0;
                        gnt_i_q <= 1'b0;
                        gnt_d_q <= 1'b0;
                        addr_q  <= '0;
                    end else if (beat) begin
                        count <= count + IDX_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
`ifndef ARB_IMEM_PRIORITY_EN
                    last_dmem <= owner_d;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_i    = gnt_i_q;
    assign bus.gnt_d    = gnt_d_q;
    assign bus.mm_re    = gnt_i_q | gnt_d_q;
    assign bus.mm_addr  = addr_q;
    // Beats pass straight through to the owner with no added latency
    assign bus.valid_i  = beat && !owner_d;
    assign bus.valid_d  = beat && owner_d;
    assign bus.rdata    = beat ? bus.mm_data : '0;
    assign bus.beat_idx = beat ? count : '0;
    assign bus.done_i   = last && !owner_d;
    assign bus.done_d   = last && owner_d;
endmodule

// File: tb/tb_refill_arbiter.sv
// Scoreboard bench for refill_arbiter: stimulus queues expected grants/beats,
// a negedge monitor pops and compares whenever the DUT grants or forwards a beat.
module tb_refill_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WPL = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    refill_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) bus();

    refill_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        side;
        logic [1:0]  idx;
        logic [31:0] data;
        logic        done;
        logic [31:0] addr;
    } beat_t;

    typedef struct {
        logic        side;
        logic [31:0] addr;
    } gnt_t;

    beat_t exp_beats[$];
    gnt_t  exp_gnts[$];
    int    compared   = 0;
    int    mismatched = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic  prev_gi = 1'b0;
    logic  prev_gd = 1'b0;
    beat_t mb;
    gnt_t  mg;

    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_excl", bus.gnt_i & bus.gnt_d, 0);
            if ((bus.gnt_i && !prev_gi) || (bus.gnt_d && !prev_gd)) begin
                if (exp_gnts.size() == 0) begin
                    check("unexp_gnt", {bus.gnt_i, bus.gnt_d}, 0);
                end else begin
                    mg = exp_gnts.pop_front();
                    check("gnt_side", {bus.gnt_i, bus.gnt_d},
                          {!mg.side, mg.side});
                    check("gnt_addr", bus.mm_addr, mg.addr);
                    check("gnt_re", bus.mm_re, 1);
                end
            end
            if (bus.valid_i || bus.valid_d) begin
                if (exp_beats.size() == 0) begin
                    check("unexp_beat", {bus.valid_i, bus.valid_d}, 0);
                end else begin
                    mb = exp_beats.pop_front();
                    check("beat_side", {bus.valid_i, bus.valid_d},
                          {!mb.side, mb.side});
                    check("beat_idx", bus.beat_idx, mb.idx);
                    check("beat_data", bus.rdata, mb.data);
                    check("beat_done", {bus.done_i, bus.done_d},
                          {!mb.side && mb.done, mb.side && mb.done});
                    check("beat_addr", bus.mm_addr, mb.addr);
                    check("beat_re", bus.mm_re, 1);
                end
            end else begin
                check("nobeat_done", {bus.done_i, bus.done_d}, 0);
                check("nobeat_rdata", bus.rdata, 0);
            end
        end
        prev_gi = bus.gnt_i;
        prev_gd = bus.gnt_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input logic side, input int exp_cyc,
                            input string name);
        int cyc  = 0;
        bit seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = side ? bus.gnt_d : bus.gnt_i;
        end
        check(name, seen ? cyc : 999, exp_cyc);
    endtask

    task automatic run_beats(input logic side, input logic [31:0] base,
                             input logic [31:0] addr, input logic [15:0] pat,
                             input int n, input int start);
        int idx = start;
        for (int k = 0; k < n; k++) begin
            bus.mm_valid = pat[k];
            bus.mm_data  = pat[k] ? base + 32'(idx) : 32'hDEAD;
            if (pat[k]) begin
                exp_beats.push_back('{side, 2'(idx), base + 32'(idx),
                                      idx == WPL - 1, addr});
                idx++;
            end
            tick();
        end
        bus.mm_valid = 1'b0;
        bus.mm_data  = '0;
    endtask

    task automatic check_zero(input string tag);
        #1;
        check({tag, "_ctl"},
              {bus.gnt_i, bus.gnt_d, bus.mm_re, bus.valid_i, bus.valid_d,
               bus.done_i, bus.done_d, bus.beat_idx}, 0);
        check({tag, "_addr"}, bus.mm_addr, 0);
        check({tag, "_rdata"}, bus.rdata, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] seq;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.req_i    = 1'b0;
        bus.req_d    = 1'b0;
        bus.addr_i   = '0;
        bus.addr_d   = '0;
        bus.mm_valid = 1'b0;
        bus.mm_data  = '0;
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;

        // 1: single imem miss, address change mid-burst ignored
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_1234;
        exp_gnts.push_back('{1'b0, 32'h0000_1230});
        wait_gnt(1'b0, 1, "t1_gnt_lat");
        bus.addr_i = 32'hFFFF_FFFF;
        run_beats(1'b0, 32'hA0, 32'h0000_1230, 16'hF, 4, 0);
        bus.req_i = 1'b0;
        check_zero("t1_release");
        tick();
        tick();

        // 2: both held from reset
        do_reset();
`ifdef ARB_IMEM_PRIORITY_EN
        seq = 4'b0000;
`else
        seq = 4'b1010;
`endif
        bus.req_i  = 1'b1;
        bus.req_d  = 1'b1;
        bus.addr_i = 32'h0000_2004;
        bus.addr_d = 32'h0000_3010;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] a;
            a = seq[k] ? 32'h0000_3010 : 32'h0000_2000;
            exp_gnts.push_back('{seq[k], a});
            wait_gnt(seq[k], (k == 0) ? 1 : 2, "t2_gnt_lat");
            run_beats(seq[k], 32'h100 * (k + 1), a, 16'hF, 4, 0);
        end
        bus.req_i = 1'b0;
        bus.req_d = 1'b0;
        tick();
        tick();

        // 3: gapped beats on a dmem burst
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h0000_4008;
        exp_gnts.push_back('{1'b1, 32'h0000_4000});
        wait_gnt(1'b1, 1, "t3_gnt_lat");
        run_beats(1'b1, 32'hB0, 32'h0000_4000, 16'b1011001, 7, 0);
        bus.req_d = 1'b0;
        check("t3_beats_left", exp_beats.size(), 0);

        // 4: stray mm_valid in RELEASE and IDLE
        bus.mm_valid = 1'b1;
        bus.mm_data  = 32'hDEAD;
        check_zero("t4_release");
        tick();
        check_zero("t4_idle");
        bus.mm_valid = 1'b0;
        bus.mm_data  = '0;
        bus.req_i    = 1'b1;
        bus.addr_i   = 32'h0000_5004;
        exp_gnts.push_back('{1'b0, 32'h0000_5000});
        wait_gnt(1'b0, 1, "t4_gnt_lat");
        run_beats(1'b0, 32'hD0, 32'h0000_5000, 16'hF, 4, 0);
        bus.req_i = 1'b0;
        tick();
        tick();

        // 5: reset after two dmem beats
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h0000_6000;
        exp_gnts.push_back('{1'b1, 32'h0000_6000});
        wait_gnt(1'b1, 1, "t5_gnt_lat");
        run_beats(1'b1, 32'hC0, 32'h0000_6000, 16'h3, 2, 0);
        reset = 1'b1;
        tick();
        check_zero("t5_reset");
        reset      = 1'b0;
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_7000;
        exp_gnts.push_back('{1'b0, 32'h0000_7000});
        exp_gnts.push_back('{1'b1, 32'h0000_6000});
        wait_gnt(1'b0, 1, "t5_tie_imem");
        run_beats(1'b0, 32'hE0, 32'h0000_7000, 16'hF, 4, 0);
        bus.req_i = 1'b0;
        wait_gnt(1'b1, 2, "t5_regnt_dmem");
        run_beats(1'b1, 32'hC0, 32'h0000_6000, 16'hF, 4, 0);
        bus.req_d = 1'b0;
        tick();
        tick();

        // 6: dmem request raised during an imem burst
        bus.req_i  = 1'b1;
        bus.addr_i = 32'h0000_8000;
        exp_gnts.push_back('{1'b0, 32'h0000_8000});
        wait_gnt(1'b0, 1, "t6_gnt_lat");
        run_beats(1'b0, 32'h10, 32'h0000_8000, 16'h3, 2, 0);
        bus.req_d  = 1'b1;
        bus.addr_d = 32'h0000_9000;
        run_beats(1'b0, 32'h10, 32'h0000_8000, 16'h3, 2, 2);
        exp_gnts.push_back('{1'b1, 32'h0000_9000});
        bus.req_i = 1'b0;
        wait_gnt(1'b1, 2, "t6_gnt_gap");
        run_beats(1'b1, 32'h20, 32'h0000_9000, 16'hF, 4, 0);
        bus.req_d = 1'b0;
        tick();
        tick();
        tick();

        check("end_beats_left", exp_beats.size(), 0);
        check("end_gnts_left", exp_gnts.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
